// File: rtl/mem_wb_stage_hs.sv
// MEM stage + MEM/WB register: req/ack data port, lane steering, load extension, flush, timeout abort.
// Latency 1 cycle + memory wait states (stall_out held meanwhile); MEM_MISALIGN_CHK_EN traps misaligned ops.
module mem_wb_stage_hs #(
  parameter int N       = 32,
  parameter int RA_W    = 5,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exmem_valid,
  input  logic            exmem_regwrite,
  input  logic            exmem_memtoreg,
  input  logic            exmem_memread,
  input  logic            exmem_memwrite,
  input  logic [2:0]      exmem_funct3,
  input  logic [N-1:0]    exmem_alures,
  input  logic [N-1:0]    exmem_wdata,
  input  logic [RA_W-1:0] exmem_rdadd,
  input  logic            flush,
  output logic            mem_req,
  output logic            mem_we,
  output logic [N-1:0]    mem_addr,
  output logic [N-1:0]    mem_wdata,
  output logic [N/8-1:0]  mem_be,
  input  logic [N-1:0]    mem_rdata,
  input  logic            mem_ack,
  output logic            stall_out,
  output logic            mem_err,
  output logic            misalign,
  output logic            memwb_valid,
  output logic            memwb_regwrite,
  output logic            memwb_memtoreg,
  output logic [N-1:0]    memwb_rdata,
  output logic [N-1:0]    memwb_alures,
  output logic [RA_W-1:0] memwb_rdadd
);
  localparam int NB   = N / 8;
  localparam int OFFW = $clog2(NB);
  localparam int CW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t        state, nextState;
  logic [CW-1:0] waitCnt, nextCnt;
  logic          dropFlag, nextDrop;

  logic            latMemread, latMemwrite, latRegwrite, latMemtoreg;
  logic [2:0]      latFunct3;
  logic [N-1:0]    latAlures, latWdata;
  logic [RA_W-1:0] latRdadd;

  logic            curMemread, curMemwrite, curRegwrite, curMemtoreg;
  logic [2:0]      curFunct3;
  logic [N-1:0]    curAlures, curWdata;
  logic [RA_W-1:0] curRdadd;

  logic [OFFW-1:0] rawOff, alignMask, effOff;
  logic [NB-1:0]   beRaw;
  logic [N-1:0]    shifted, lowMask, loadExt;
  logic            signBit, misalignHit, opNow;
  logic            reqInt, timeoutHit, misalignInt;

  logic            nValid, nRegwrite, nMemtoreg;
  logic [N-1:0]    nRdata, nAlures;
  logic [RA_W-1:0] nRdadd;

  // While waiting, the access is replayed from the latch so the bus stays stable
  // even if the upstream register is disturbed by a flush.
  always_comb begin
    if (state == ST_WAIT) begin
      curMemread  = latMemread;
      curMemwrite = latMemwrite;
      curRegwrite = latRegwrite;
      curMemtoreg = latMemtoreg;
      curFunct3   = latFunct3;
      curAlures   = latAlures;
      curWdata    = latWdata;
      curRdadd    = latRdadd;
    end else begin
      curMemread  = exmem_memread;
      curMemwrite = exmem_memwrite;
      curRegwrite = exmem_regwrite;
      curMemtoreg = exmem_memtoreg;
      curFunct3   = exmem_funct3;
      curAlures   = exmem_alures;
      curWdata    = exmem_wdata;
      curRdadd    = exmem_rdadd;
    end
  end

  always_comb begin
    rawOff = curAlures[OFFW-1:0];
    case (curFunct3[1:0])
      2'b00: begin
        alignMask = '0;
        beRaw     = NB'(1);
        lowMask   = N'(8'hFF);
      end
      2'b01: begin
        alignMask = OFFW'(1);
        beRaw     = NB'(3);
        lowMask   = N'(16'hFFFF);
      end
      2'b10: begin
        alignMask = OFFW'(3);
        beRaw     = NB'(4'hF);
        lowMask   = N'(32'hFFFF_FFFF);
      end
      default: begin
        alignMask = '1;
        beRaw     = '1;
        lowMask   = '1;
      end
    endcase
    effOff  = rawOff & ~alignMask;
    shifted = mem_rdata >> {effOff, 3'b000};
    case (curFunct3[1:0])
      2'b00:   signBit = shifted[7];
      2'b01:   signBit = shifted[15];
      2'b10:   signBit = shifted[31];
      default: signBit = shifted[N-1];
    endcase
    loadExt = (shifted & lowMask) | ({N{signBit & ~curFunct3[2]}} & ~lowMask);
  end

`ifdef MEM_MISALIGN_CHK_EN
  assign misalignHit = |(rawOff & alignMask);
`else
  assign misalignHit = 1'b0;
`endif

  assign opNow = exmem_valid & (exmem_memread | exmem_memwrite);

  always_comb begin
    nextState   = state;
    nextCnt     = waitCnt;
    nextDrop    = dropFlag;
    reqInt      = 1'b0;
    timeoutHit  = 1'b0;
    misalignInt = 1'b0;
    nValid      = 1'b0;
    nRegwrite   = 1'b0;
    nMemtoreg   = 1'b0;
    nRdata      = '0;
    nAlures     = '0;
    nRdadd      = '0;
    case (state)
      ST_IDLE: begin
        if (flush) begin
          nValid = 1'b0;
        end else if (opNow && misalignHit) begin
          misalignInt = 1'b1;
        end else if (opNow) begin
          reqInt = 1'b1;
          if (mem_ack) begin
            nValid    = 1'b1;
            nRegwrite = curRegwrite;
            nMemtoreg = curMemtoreg;
            nRdata    = curMemread ? loadExt : '0;
            nAlures   = curAlures;
            nRdadd    = curRdadd;
          end else begin
            nextState = ST_WAIT;
            nextCnt   = CW'(1);
          end
        end else begin
          nValid    = exmem_valid;
          nRegwrite = exmem_valid & exmem_regwrite;
          nMemtoreg = exmem_valid & exmem_memtoreg;
          nAlures   = exmem_alures;
          nRdadd    = exmem_rdadd;
        end
      end
      ST_WAIT: begin
        if (mem_ack) begin
          // A flush seen at any point of the wait turns the result into a bubble.
          reqInt    = 1'b1;
          nValid    = ~(dropFlag | flush);
          nRegwrite = ~(dropFlag | flush) & curRegwrite;
          nMemtoreg = ~(dropFlag | flush) & curMemtoreg;
          nRdata    = curMemread ? loadExt : '0;
          nAlures   = curAlures;
          nRdadd    = curRdadd;
          nextState = ST_IDLE;
          nextCnt   = '0;
          nextDrop  = 1'b0;
        end else if (waitCnt == TO_CNT) begin
          timeoutHit = 1'b1;
          nextState  = ST_IDLE;
          nextCnt    = '0;
          nextDrop   = 1'b0;
        end else begin
          reqInt   = 1'b1;
          nextCnt  = waitCnt + CW'(1);
          nextDrop = dropFlag | flush;
        end
      end
      default: nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      waitCnt  <= '0;
      dropFlag <= 1'b0;
    end else begin
      state    <= nextState;
      waitCnt  <= nextCnt;
      dropFlag <= nextDrop;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latMemread  <= 1'b0;
      latMemwrite <= 1'b0;
      latRegwrite <= 1'b0;
      latMemtoreg <= 1'b0;
      latFunct3   <= '0;
      latAlures   <= '0;
      latWdata    <= '0;
      latRdadd    <= '0;
    end else if (state == ST_IDLE) begin
      latMemread  <= exmem_memread;
      latMemwrite <= exmem_memwrite;
      latRegwrite <= exmem_regwrite;
      latMemtoreg <= exmem_memtoreg;
      latFunct3   <= exmem_funct3;
      latAlures   <= exmem_alures;
      latWdata    <= exmem_wdata;
      latRdadd    <= exmem_rdadd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memwb_valid    <= 1'b0;
      memwb_regwrite <= 1'b0;
      memwb_memtoreg <= 1'b0;
      memwb_rdata    <= '0;
      memwb_alures   <= '0;
      memwb_rdadd    <= '0;
    end else begin
      memwb_valid    <= nValid;
      memwb_regwrite <= nRegwrite;
      memwb_memtoreg <= nMemtoreg;
      memwb_rdata    <= nRdata;
      memwb_alures   <= nAlures;
      memwb_rdadd    <= nRdadd;
    end
  end

  assign mem_req   = reqInt & ~rst;
  assign mem_we    = curMemwrite;
  assign mem_addr  = {curAlures[N-1:OFFW], {OFFW{1'b0}}};
  assign mem_wdata = curWdata << {effOff, 3'b000};
  assign mem_be    = beRaw << effOff;
  assign stall_out = mem_req & ~mem_ack;
  assign mem_err   = timeoutHit & ~rst;
  assign misalign  = misalignInt & ~rst;
endmodule

// File: tb/tb_mem_wb_stage_hs.sv
// Randomized + directed bench for mem_wb_stage_hs (N=32) against a transaction-level model.
module tb_mem_wb_stage_hs;
  localparam int N = 32, RA_W = 5, TIMEOUT = 15;

  logic clk = 1'b0, rst;
  logic exmem_valid, exmem_regwrite, exmem_memtoreg, exmem_memread, exmem_memwrite;
  logic [2:0] exmem_funct3;
  logic [N-1:0] exmem_alures, exmem_wdata;
  logic [RA_W-1:0] exmem_rdadd;
  logic flush, mem_req, mem_we, mem_ack, stall_out, mem_err, misalign;
  logic [N-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [N/8-1:0] mem_be;
  logic memwb_valid, memwb_regwrite, memwb_memtoreg;
  logic [N-1:0] memwb_rdata, memwb_alures;
  logic [RA_W-1:0] memwb_rdadd;

  int checks = 0, failures = 0;

  mem_wb_stage_hs #(.N(N), .RA_W(RA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .exmem_valid(exmem_valid), .exmem_regwrite(exmem_regwrite), .exmem_memtoreg(exmem_memtoreg),
    .exmem_memread(exmem_memread), .exmem_memwrite(exmem_memwrite), .exmem_funct3(exmem_funct3),
    .exmem_alures(exmem_alures), .exmem_wdata(exmem_wdata), .exmem_rdadd(exmem_rdadd),
    .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_out(stall_out),
    .mem_err(mem_err), .misalign(misalign), .memwb_valid(memwb_valid),
    .memwb_regwrite(memwb_regwrite), .memwb_memtoreg(memwb_memtoreg), .memwb_rdata(memwb_rdata),
    .memwb_alures(memwb_alures), .memwb_rdadd(memwb_rdadd)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // kind: 0 non-mem, 1 load, 2 store. lat: ack after lat extra cycles (>TIMEOUT = never).
  // flushAt: cycle of the transaction in which flush pulses (-1 none).
  task automatic runOp(input logic v, input int kind, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd, input logic rw, input logic m2r,
                       input logic [4:0] rdad, input int lat, input int flushAt);
    bit isOp, misal, issues, tmo, kept, reqExp, ackNow;
    int sz, off, eff, nCyc, reqCycles;
    logic [31:0] expBe, expWd, mask, val;
    isOp = v && (kind != 0);
    sz = 1 << f3[1:0];
    if (sz > 4) sz = 4;
    off = int'(addr % 4);
    eff = off - (off % sz);
    misal = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
    misal = isOp && (off % sz != 0);
`endif
    issues = isOp && (flushAt != 0) && !misal;
    tmo = issues && (lat > TIMEOUT);
    reqCycles = !issues ? 0 : (tmo ? TIMEOUT : lat + 1);
    nCyc = !issues ? 1 : (tmo ? TIMEOUT + 1 : lat + 1);
    kept = v && !(flushAt >= 0 && flushAt < nCyc) && !tmo && !misal;
    expBe = ((32'd1 << sz) - 1) << eff;
    expWd = wd << (8 * eff);
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 1);
    val = (rd >> (8 * eff)) & mask;
    if (!f3[2] && sz < 4 && val[8*sz-1]) val = val | ~mask;
    for (int c = 0; c < nCyc; c++) begin
      @(negedge clk);
      if (c > 0) checkVal("wbBubbleWhileWait", memwb_valid, 0);
      ackNow = issues && !tmo && (c == lat);
      exmem_valid = v; exmem_memread = (kind == 1); exmem_memwrite = (kind == 2);
      exmem_funct3 = f3; exmem_alures = addr; exmem_wdata = wd; exmem_rdadd = rdad;
      exmem_regwrite = rw; exmem_memtoreg = m2r; flush = (c == flushAt);
      mem_ack = ackNow; mem_rdata = rd;
      #1;
      reqExp = (c < reqCycles);
      checkVal("memReq", mem_req, reqExp);
      checkVal("stall", stall_out, reqExp && !ackNow);
      checkVal("memErr", mem_err, tmo && (c == TIMEOUT));
      checkVal("misalign", misalign, misal && (flushAt != 0) && (c == 0));
      if (reqExp) begin
        checkVal("memAddr", mem_addr, addr & 32'hFFFF_FFFC);
        checkVal("memBe", mem_be, expBe[3:0]);
        checkVal("memWe", mem_we, kind == 2);
        if (kind == 2) checkVal("memWdata", mem_wdata, expWd);
      end
    end
    @(posedge clk); #1;
    mem_ack = 1'b0; flush = 1'b0;
    checkVal("wbValid", memwb_valid, kept);
    checkVal("wbRegwrite", memwb_regwrite, kept && rw);
    checkVal("wbMemtoreg", memwb_memtoreg, kept && m2r);
    if (kept) begin
      checkVal("wbAlures", memwb_alures, addr);
      checkVal("wbRdadd", memwb_rdadd, rdad);
      if (kind == 1) checkVal("wbRdata", memwb_rdata, val);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic v, rw, m2r;
    logic [2:0] f3;
    int kind, lat, fl, r;
    rst = 1'b1;
    exmem_valid = 1'b1; exmem_memread = 1'b1; exmem_memwrite = 1'b0; exmem_funct3 = 3'b010;
    exmem_alures = 32'h100; exmem_wdata = '0; exmem_rdadd = 5'd1; exmem_regwrite = 1'b1;
    exmem_memtoreg = 1'b1; flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    #1;
    checkVal("rstMemReq", mem_req, 0);
    checkVal("rstMemErr", mem_err, 0);
    checkVal("rstMisalign", misalign, 0);
    repeat (2) @(posedge clk);
    #1;
    checkVal("rstWbValid", memwb_valid, 0);
    checkVal("rstWbRegwrite", memwb_regwrite, 0);
    checkVal("rstWbRdata", memwb_rdata, 0);
    checkVal("rstWbAlures", memwb_alures, 0);
    @(negedge clk);
    exmem_valid = 1'b0;
    rst = 1'b0;

    runOp(1, 1, 3'b000, 32'h103, 0, 32'h80FF_FF12, 1, 1, 5'd3, 0, -1);
    runOp(1, 1, 3'b101, 32'h102, 0, 32'hBEEF_0000, 1, 1, 5'd4, 3, -1);
    runOp(1, 2, 3'b000, 32'h101, 32'hAB, 0, 0, 0, 5'd0, 0, -1);
    runOp(1, 1, 3'b010, 32'h200, 0, 32'h1234, 1, 1, 5'd7, TIMEOUT + 10, -1);
    runOp(1, 1, 3'b010, 32'h204, 0, 32'h5555, 1, 1, 5'd8, 3, 1);
    runOp(1, 1, 3'b010, 32'h102, 0, 32'hCAFE_F00D, 1, 1, 5'd9, 1, -1);
    runOp(1, 1, 3'b010, 32'h300, 0, 32'h7777, 1, 1, 5'd10, 2, 0);
    runOp(1, 1, 3'b010, 32'h304, 0, 32'h8888, 1, 1, 5'd11, 2, 2);
    runOp(1, 1, 3'b010, 32'h308, 0, 32'h9999, 1, 1, 5'd12, TIMEOUT, -1);
    runOp(1, 2, 3'b001, 32'h106, 32'h1234, 0, 0, 0, 5'd0, 1, -1);
    runOp(1, 1, 3'b001, 32'h102, 0, 32'h8001_0000, 1, 1, 5'd13, 0, -1);
    runOp(1, 0, 3'b000, 32'hDEAD_BEEF, 0, 0, 1, 0, 5'd14, 0, -1);
    runOp(0, 1, 3'b010, 32'h400, 0, 0, 1, 1, 5'd15, 0, -1);

    // Asynchronous reset in the middle of a pending access.
    runOp(1, 0, 3'b000, 32'h55, 0, 0, 1, 0, 5'd16, 0, -1);
    exmem_valid = 1'b1; exmem_memread = 1'b1; exmem_memwrite = 1'b0; exmem_funct3 = 3'b010;
    exmem_alures = 32'h500; mem_ack = 1'b0;
    #1;
    checkVal("preRstReq", mem_req, 1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checkVal("asyncRstReq", mem_req, 0);
    checkVal("asyncRstStall", stall_out, 0);
    checkVal("asyncRstWbValid", memwb_valid, 0);
    @(negedge clk);
    exmem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    runOp(1, 1, 3'b010, 32'h600, 0, 0, 1, 1, 5'd17, TIMEOUT + 3, -1);

    for (int i = 0; i < 150; i++) begin
      v = ($urandom_range(0, 9) != 0);
      kind = $urandom_range(0, 2);
      f3 = 3'($urandom_range(0, 7));
      if (f3[1:0] == 2'b11) f3[1:0] = 2'b10;
      rw = 1'($urandom_range(0, 1));
      m2r = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      lat = (r < 12) ? (r % 4) : ((r < 15) ? $urandom_range(4, 8) : ((r < 17) ? TIMEOUT : TIMEOUT + 5));
      fl = ($urandom_range(0, 7) == 0) ? $urandom_range(0, (lat > TIMEOUT) ? TIMEOUT : lat) : -1;
      runOp(v, kind, f3, $urandom, $urandom, $urandom, rw, m2r, 5'($urandom_range(0, 31)), lat, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
